// File: rtl/vga_timing_pkg.sv
// VGA raster timing constants and decode bundle.
// Defaults are 800x600@72 on a 50 MHz pixel clock.
package vga_timing_pkg;

  localparam int ADDR_W = 11;

  localparam int H_SYNC_DEF   = 120;
  localparam int H_BACK_DEF   = 64;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 56;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BACK_DEF   = 23;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FRONT_DEF  = 37;

  localparam int H_TOTAL_DEF =
    H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL_DEF =
    V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
  localparam int H_START_DEF = H_SYNC_DEF + H_BACK_DEF;
  localparam int V_START_DEF = V_SYNC_DEF + V_BACK_DEF;

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              active;
    logic              fs;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
  } vga_dec_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for the {vsync,hsync} pair.
// Depth 0 degenerates to a wire.
module sync_delay_line #(
  parameter int         DEPTH   = 2,
  parameter logic [1:0] RST_VAL = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d_i,
  output logic [1:0] d_o
);

  if (DEPTH == 0) begin : g_pass
    assign d_o = d_i;
  end else begin : g_pipe
    logic [1:0] stage_q [DEPTH];

    // shift sync levels; reset loads the deasserted level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign d_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_module.sv
// Free-running VGA raster counter with registered decode.
// Sync outputs are delayed to match the colour mixer pipeline.
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              sync_ready_sig,
  output logic [ADDR_W-1:0] column_addr_sig,
  output logic [ADDR_W-1:0] row_addr_sig,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_SY   = ADDR_W'(H_SYNC);
  localparam logic [ADDR_W-1:0] V_SY   = ADDR_W'(V_SYNC);
  localparam logic [ADDR_W-1:0] H_BEG  = ADDR_W'(H_START);
  localparam logic [ADDR_W-1:0] V_BEG  = ADDR_W'(V_START);
  localparam logic [ADDR_W-1:0] H_END  = ADDR_W'(H_START + H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_END  = ADDR_W'(V_START + V_ACTIVE);

  localparam logic       DEASSERT = ~SYNC_POL;
  localparam logic [1:0] SYNC_RST = {DEASSERT, DEASSERT};

  logic [ADDR_W-1:0] h_cnt_q, h_cnt_d;
  logic [ADDR_W-1:0] v_cnt_q, v_cnt_d;
  vga_dec_t          dec_q, dec_d;
  logic              h_act, v_act;
  logic [1:0]        sync_dly;

  // raster counters: h every clock, v on each line wrap
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // position decode; sync levels already carry polarity
  always_comb begin
    h_act        = (h_cnt_q >= H_BEG) && (h_cnt_q < H_END);
    v_act        = (v_cnt_q >= V_BEG) && (v_cnt_q < V_END);
    dec_d        = '0;
    dec_d.hs     = (h_cnt_q < H_SY) ? SYNC_POL : DEASSERT;
    dec_d.vs     = (v_cnt_q < V_SY) ? SYNC_POL : DEASSERT;
    dec_d.active = h_act && v_act;
    dec_d.fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
    if (dec_d.active) begin
      dec_d.col = h_cnt_q - H_BEG;
      dec_d.row = v_cnt_q - V_BEG;
    end
  end

  // one decode stage, all outputs coincident
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q    <= '0;
      dec_q.hs <= DEASSERT;
      dec_q.vs <= DEASSERT;
    end else begin
      dec_q <= dec_d;
    end
  end

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_RST)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({dec_q.vs, dec_q.hs}),
    .d_o   (sync_dly)
  );

  assign hsync_out       = sync_dly[0];
  assign vsync_out       = sync_dly[1];
  assign sync_ready_sig  = dec_q.active;
  assign column_addr_sig = dec_q.col;
  assign row_addr_sig    = dec_q.row;
  assign frame_start     = dec_q.fs;

endmodule
